// File: rtl/committed_store_buffer.sv
// committed_store_buffer: post-commit store FIFO between ROB commit and the d-cache.
// Stores retire in order, drain one per handshake, and a combinational query
// flags loads that alias a buffered or incoming store.
// Optional feature macro: STORE_FWD_EN (forward youngest matching store data).
module committed_store_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_valid,
  input  logic [ADDR_WIDTH-1:0]   commit_addr,
  input  logic [DATA_WIDTH-1:0]   commit_data,
  output logic                    commit_ready,
  output logic                    drain_valid,
  output logic [ADDR_WIDTH-1:0]   drain_addr,
  output logic [DATA_WIDTH-1:0]   drain_data,
  input  logic                    drain_ready,
  input  logic [ADDR_WIDTH-1:0]   ld_query_addr,
  output logic                    ld_query_hit,
  output logic [DATA_WIDTH-1:0]   ld_query_data,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [DEPTH];

  logic [IW-1:0]           wr_idx;
  logic [IW-1:0]           rd_idx;
  logic [PW-1:0]           count_w;
  logic                    full_w;
  logic                    empty_w;
  logic                    commit_fire;
  logic                    drain_fire;

  // Committed stores are architectural; flush intentionally has no effect.
  logic unused_flush;
  assign unused_flush = flush;

  // Pointer-derived occupancy and handshake qualifiers.
  always_comb begin
    wr_idx      = wr_ptr_q[IW-1:0];
    rd_idx      = rd_ptr_q[IW-1:0];
    count_w     = wr_ptr_q - rd_ptr_q;
    empty_w     = (wr_ptr_q == rd_ptr_q);
    full_w      = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    commit_fire = commit_valid && !full_w;
    drain_fire  = (state_q == ISSUE) && drain_ready;
  end

  // Storage and pointer next-state: write at wr_ptr on commit, retire at rd_ptr on drain.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (commit_fire) begin
      valid_d[wr_idx] = 1'b1;
      addr_d[wr_idx]  = commit_addr;
      data_d[wr_idx]  = commit_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (drain_fire) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
  end

  // Drain FSM next state: stay in ISSUE only while another entry remains behind the head.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty_w) state_d = ISSUE;
      ISSUE:   if (drain_ready) state_d = (count_w >= PW'(2)) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Status and drain outputs; head fields are zeroed whenever nothing is presented.
  always_comb begin
    commit_ready = !full_w;
    count        = count_w;
    empty        = empty_w;
    drain_valid  = (state_q == ISSUE);
    drain_addr   = drain_valid ? addr_q[rd_idx] : '0;
    drain_data   = drain_valid ? data_q[rd_idx] : '0;
  end

  // Load query: scan oldest to youngest so the last match wins, then let the
  // incoming commit override as the youngest store of all.
  always_comb begin
    logic [IW-1:0] idx;
`ifdef STORE_FWD_EN
    logic [DATA_WIDTH-1:0] fwd;
    fwd = '0;
`endif
    idx          = '0;
    ld_query_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_idx + IW'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_query_addr)) begin
        ld_query_hit = 1'b1;
`ifdef STORE_FWD_EN
        fwd = data_q[idx];
`endif
      end
    end
    if (commit_fire && (commit_addr == ld_query_addr)) begin
      ld_query_hit = 1'b1;
`ifdef STORE_FWD_EN
      fwd = commit_data;
`endif
    end
`ifdef STORE_FWD_EN
    ld_query_data = fwd;
`else
    ld_query_data = '0;
`endif
  end

endmodule

// File: tb/tb_committed_store_buffer.sv
// Testbench for committed_store_buffer: queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_committed_store_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_addr = '0;
  logic [31:0] commit_data = '0;
  logic        commit_ready;
  logic        drain_valid;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic        drain_ready = 1'b0;
  logic [31:0] ld_query_addr = 32'h999;
  logic        ld_query_hit;
  logic [31:0] ld_query_data;
  logic        flush = 1'b0;
  logic [3:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  committed_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_ready(commit_ready),
    .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_ready(drain_ready),
    .ld_query_addr(ld_query_addr), .ld_query_hit(ld_query_hit), .ld_query_data(ld_query_data),
    .flush(flush), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t mq[$];
  logic mdv = 1'b0;   // model: head is being presented

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mdv = 1'b0;
    end else begin
      int  held;
      bit  dr, cm;
      held = mq.size();
      dr   = mdv && drain_ready;
      cm   = commit_valid && (held < DEPTH);
      if (mdv) mdv = dr ? (held >= 2) : 1'b1;
      else     mdv = (held > 0);
      if (dr) void'(mq.pop_front());
      if (cm) mq.push_back('{commit_addr, commit_data});
    end
  end

  // Stall tracking for the stability check.
  bit          stall_prev = 1'b0;
  logic [31:0] prev_a, prev_d;

  always @(negedge clk) begin
    logic        e_hit;
    logic [31:0] e_data;
    logic [31:0] e_da, e_dd;
    e_hit  = 1'b0;
    e_data = '0;
    foreach (mq[i]) if (mq[i].a == ld_query_addr) begin e_hit = 1'b1; e_data = mq[i].d; end
    if (commit_valid && mq.size() < DEPTH && commit_addr == ld_query_addr) begin
      e_hit = 1'b1; e_data = commit_data;
    end
`ifndef STORE_FWD_EN
    e_data = '0;
`endif
    e_da = mdv ? mq[0].a : 32'h0;
    e_dd = mdv ? mq[0].d : 32'h0;
    chk("m_commit_ready", 64'(commit_ready), 64'(mq.size() < DEPTH));
    chk("m_count",        64'(count),        64'(mq.size()));
    chk("m_empty",        64'(empty),        64'(mq.size() == 0));
    chk("m_drain_valid",  64'(drain_valid),  64'(mdv));
    chk("m_drain_addr",   64'(drain_addr),   64'(e_da));
    chk("m_drain_data",   64'(drain_data),   64'(e_dd));
    chk("m_query_hit",    64'(ld_query_hit), 64'(e_hit));
    chk("m_query_data",   64'(ld_query_data),64'(e_data));
    if (stall_prev && rst_n) begin
      chk("stable_addr", 64'(drain_addr), 64'(prev_a));
      chk("stable_data", 64'(drain_data), 64'(prev_d));
    end
    stall_prev = rst_n && mdv && !drain_ready;
    prev_a     = e_da;
    prev_d     = e_dd;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] a, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_data  = d;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic drain_all(input string name);
    drain_ready = 1'b1;
    for (int k = 0; k < 20 && (mq.size() != 0 || mdv); k++) tick();
    drain_ready = 1'b0;
    @(negedge clk);
    chk(name, 64'(empty), 64'(1));
    tick();
  endtask

  initial begin
    // Reset with commit_valid held high.
    rst_n = 1'b0;
    commit_valid = 1'b1;
    commit_addr  = 32'h100;
    commit_data  = 32'h1;
    ld_query_addr = 32'h999;
    repeat (2) @(negedge clk);
    chk("rst_commit_ready", 64'(commit_ready), 64'(1));
    chk("rst_drain_valid",  64'(drain_valid),  64'(0));
    chk("rst_count",        64'(count),        64'(0));
    chk("rst_empty",        64'(empty),        64'(1));
    chk("rst_drain_addr",   64'(drain_addr),   64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    commit_valid = 1'b0;
    tick();

    // Single commit: presented after two edges.
    do_commit(32'h100, 32'hAAAA);
    @(negedge clk);
    chk("lat_not_yet", 64'(drain_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("lat_valid", 64'(drain_valid), 64'(1));
    chk("lat_addr",  64'(drain_addr),  64'(32'h100));
    chk("lat_data",  64'(drain_data),  64'(32'hAAAA));
    tick();
    drain_all("lat_empty");

    // Fill to DEPTH, 9th commit ignored, then drain in order.
    for (int i = 0; i < 8; i++) do_commit(32'h1000 + 32'(4 * i), 32'h10 + 32'(i));
    @(negedge clk);
    chk("full_count", 64'(count),        64'(8));
    chk("full_ready", 64'(commit_ready), 64'(0));
    tick();
    do_commit(32'hDEAD0, 32'hBAD);
    @(negedge clk);
    chk("ninth_ignored", 64'(count), 64'(8));
    tick();
    drain_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("order_addr", 64'(drain_addr), 64'(32'h1000 + 32'(4 * i)));
      chk("order_data", 64'(drain_data), 64'(32'h10 + 32'(i)));
      tick();
    end
    drain_ready = 1'b0;
    @(negedge clk);
    chk("full_drained_empty", 64'(empty), 64'(1));
    tick();

    // Youngest-match query.
    do_commit(32'h200, 32'h1);
    do_commit(32'h200, 32'h2);
    ld_query_addr = 32'h200;
    @(negedge clk);
    chk("q_hit", 64'(ld_query_hit), 64'(1));
`ifdef STORE_FWD_EN
    chk("q_data", 64'(ld_query_data), 64'(2));
`else
    chk("q_data", 64'(ld_query_data), 64'(0));
`endif
    tick();
    ld_query_addr = 32'h204;
    @(negedge clk);
    chk("q_miss", 64'(ld_query_hit), 64'(0));
    tick();
    drain_all("q_empty");

    // Incoming commit hits in the same cycle on an empty buffer.
    commit_valid  = 1'b1;
    commit_addr   = 32'h300;
    commit_data   = 32'h5;
    ld_query_addr = 32'h300;
    @(negedge clk);
    chk("inc_hit", 64'(ld_query_hit), 64'(1));
`ifdef STORE_FWD_EN
    chk("inc_data", 64'(ld_query_data), 64'(5));
`else
    chk("inc_data", 64'(ld_query_data), 64'(0));
`endif
    tick();
    commit_valid = 1'b0;
    drain_all("inc_empty");

    // Random commit/drain pairs with back-pressure.
    begin
      int sent = 0;
      for (int cyc = 0; cyc < 600 && !(sent == 20 && mq.size() == 0 && !mdv); cyc++) begin
        commit_valid  = (sent < 20) && ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH);
        commit_addr   = 32'h4000 + 32'(4 * (sent % 4));
        commit_data   = 32'h5000 + 32'(sent);
        drain_ready   = ($urandom_range(0, 3) != 0);
        ld_query_addr = 32'h4000 + 32'(4 * $urandom_range(0, 3));
        if (commit_valid) sent++;
        tick();
      end
      commit_valid = 1'b0;
      drain_ready  = 1'b0;
      chk("rand_sent", 64'(sent), 64'(20));
      @(negedge clk);
      chk("rand_drained", 64'(count), 64'(0));
      tick();
    end

    // Flush is ignored.
    for (int i = 0; i < 3; i++) do_commit(32'h600 + 32'(4 * i), 32'h60 + 32'(i));
    flush = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("flush_count", 64'(count), 64'(3));
    tick();
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_drain_addr", 64'(drain_addr), 64'(32'h600 + 32'(4 * i)));
      tick();
    end
    drain_ready = 1'b0;
    @(negedge clk);
    chk("flush_empty", 64'(empty), 64'(1));
    flush = 1'b0;
    tick();

    // Asynchronous reset mid-drain clears outputs immediately.
    do_commit(32'h700, 32'h7);
    do_commit(32'h704, 32'h8);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_drain_valid", 64'(drain_valid), 64'(0));
    chk("arst_count",       64'(count),       64'(0));
    chk("arst_empty",       64'(empty),       64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_count", 64'(count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
